spi_transaction_arbiter: RTL

Shares one bidirectional_spi core between NUM_REQ independent requesters, such as gradient DAC, attenuator and synthesizer config engines. It arbitrates round-robin and launches one masked SPI transaction at a time. It waits for that transaction to complete, then returns read data and status to the requester that issued it. The block sits in the fabric_clk domain between the requester logic and the SPI core's transaction inputs.

---
 rtl/spi_ctrl_pkg.sv | 17 +
 rtl/spi_transaction_arbiter_rr.sv | 44 ++++
 rtl/spi_transaction_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/spi_ctrl_pkg.sv
// spi_ctrl_pkg: shared types for the SPI transaction arbiter.
// Holds the controller state enum and the timeout counter width helper.
package spi_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   function automatic int cnt_width(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/spi_transaction_arbiter_rr.sv
// rr_arbiter: round-robin arbiter with a registered last-grant pointer.
// Ports: fabric_clk, reset, req (requests), advance (commit grant), grant (one-hot).
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         fabric_clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] last;
   logic [PW-1:0] win;
   logic [PW-1:0] idx;

   // Walk offsets from farthest to nearest so the nearest set bit after
   // the last grant is the one left standing.
   always_comb begin
      grant = '0;
      win   = last;
      idx   = '0;
      for (int k = N; k >= 1; k--) begin
         idx = PW'((int'(last) + k) % N);
         if (req[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
            win        = idx;
         end
      end
   end

   // Pointer starts at N-1 so requester 0 wins first after reset.
   always_ff @(posedge fabric_clk) begin
      if (reset) begin
         last <= PW'(N - 1);
      end else if (advance) begin
         last <= win;
      end
   end

endmodule

// File: rtl/spi_transaction_arbiter.sv
// spi_transaction_arbiter: shares one SPI core among NUM_REQ requesters.
// Ports: req_* (requester side), rsp_* (responses), spi_* (core side), busy.
module spi_transaction_arbiter
   import spi_ctrl_pkg::*;
#(
   parameter int NUM_REQ               = 4,
   parameter int DATA_WIDTH            = 32,
   parameter int TRANSACTION_LEN_WIDTH = 6,
   parameter int TIMEOUT_CYCLES        = 4096
) (
   input  logic                                     fabric_clk,
   input  logic                                     reset,
   input  logic [NUM_REQ-1:0]                       req_valid,
   output logic [NUM_REQ-1:0]                       req_ready,
   input  logic [NUM_REQ*TRANSACTION_LEN_WIDTH-1:0] req_length,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]            req_data,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]            req_rw_mask,
   output logic [NUM_REQ-1:0]                       rsp_valid,
   output logic [DATA_WIDTH-1:0]                    rsp_data,
   output logic                                     rsp_error,
   output logic [TRANSACTION_LEN_WIDTH-1:0]         spi_transaction_length,
   output logic [DATA_WIDTH-1:0]                    spi_transaction_data,
   output logic [DATA_WIDTH-1:0]                    spi_transaction_rw_mask,
   input  logic                                     spi_done,
   input  logic                                     spi_read_valid,
   input  logic [DATA_WIDTH-1:0]                    spi_read_data,
   output logic                                     busy
);

   localparam int LW = TRANSACTION_LEN_WIDTH;
   localparam int DW = DATA_WIDTH;
   localparam int CW = cnt_width(TIMEOUT_CYCLES);

   state_t            state;
   logic [NUM_REQ-1:0] grant_oh;
   logic [NUM_REQ-1:0] cur_oh;
   logic              advance;
   logic [LW-1:0]     sel_len;
   logic [LW-1:0]     len_q;
   logic [DW-1:0]     sel_data;
   logic [DW-1:0]     sel_mask;
   logic [DW-1:0]     data_q;
   logic [DW-1:0]     mask_q;
   logic [DW-1:0]     rd_q;
   logic [DW-1:0]     rd_now;
   logic [DW-1:0]     len_bits;
   logic              len_ok;
   logic              expect_read;
   logic              exp_q;
   logic              done_seen;
   logic              read_seen;
   logic              done_now;
   logic              read_now;
   logic              complete;
   logic [CW-1:0]     tmo_cnt;

   assign advance = (state == IDLE) && (|req_valid);

   rr_arbiter #(
      .N(NUM_REQ)
   ) u_rr (
      .fabric_clk(fabric_clk),
      .reset     (reset),
      .req       (req_valid),
      .advance   (advance),
      .grant     (grant_oh)
   );

   always_comb begin
      sel_len  = '0;
      sel_data = '0;
      sel_mask = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_oh[i]) begin
            sel_len  = req_length[i*LW +: LW];
            sel_data = req_data[i*DW +: DW];
            sel_mask = req_rw_mask[i*DW +: DW];
         end
      end
   end

   // Only mask bits inside the transfer length decide whether a read occurs.
   always_comb begin
      len_bits = '0;
      for (int i = 0; i < DW; i++) begin
         len_bits[i] = (i < int'(len_q));
      end
      len_ok      = (len_q != '0) && (int'(len_q) <= DW);
      expect_read = |(~mask_q & len_bits);
   end

   // Same-cycle pulses count toward completion alongside the latched flags.
   assign done_now = done_seen | spi_done;
   assign read_now = read_seen | (exp_q & spi_read_valid);
   assign complete = done_now & (~exp_q | read_now);
   assign rd_now   = (exp_q & spi_read_valid) ? spi_read_data : rd_q;

   always_ff @(posedge fabric_clk) begin
      if (reset) begin
         state                   <= IDLE;
         req_ready               <= '0;
         rsp_valid               <= '0;
         rsp_data                <= '0;
         rsp_error               <= 1'b0;
         spi_transaction_length  <= '0;
         spi_transaction_data    <= '0;
         spi_transaction_rw_mask <= '0;
         busy                    <= 1'b0;
         cur_oh                  <= '0;
         len_q                   <= '0;
         data_q                  <= '0;
         mask_q                  <= '0;
         rd_q                    <= '0;
         exp_q                   <= 1'b0;
         done_seen               <= 1'b0;
         read_seen               <= 1'b0;
         tmo_cnt                 <= '0;
      end else begin
         req_ready              <= '0;
         rsp_valid              <= '0;
         rsp_data               <= '0;
         rsp_error              <= 1'b0;
         spi_transaction_length <= '0;
         unique case (state)
            IDLE: begin
               if (|req_valid) begin
                  req_ready <= grant_oh;
                  cur_oh    <= grant_oh;
                  len_q     <= sel_len;
                  data_q    <= sel_data;
                  mask_q    <= sel_mask;
                  busy      <= 1'b1;
                  state     <= CHECK;
               end
            end
            CHECK: begin
               if (!len_ok) begin
                  rsp_valid <= cur_oh;
                  rsp_error <= 1'b1;
                  state     <= RESP;
               end else begin
                  exp_q                   <= expect_read;
                  spi_transaction_length  <= len_q;
                  spi_transaction_data    <= data_q;
                  spi_transaction_rw_mask <= mask_q;
                  state                   <= ISSUE;
               end
            end
            ISSUE: begin
               tmo_cnt   <= '0;
               done_seen <= 1'b0;
               read_seen <= 1'b0;
               rd_q      <= '0;
               state     <= WAIT;
            end
            WAIT: begin
               if (spi_done) begin
                  done_seen <= 1'b1;
               end
               if (exp_q && spi_read_valid) begin
                  read_seen <= 1'b1;
                  rd_q      <= spi_read_data;
               end
               if (complete) begin
                  rsp_valid <= cur_oh;
                  rsp_data  <= exp_q ? rd_now : '0;
                  state     <= RESP;
               end else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 2)) begin
                  // Response lands exactly TIMEOUT_CYCLES after launch.
                  rsp_valid <= cur_oh;
                  rsp_error <= 1'b1;
                  state     <= RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            RESP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
